// File: rtl/id_pipe.sv
// Pipelined MIPS32-subset decode: IF/ID slot, operand forwarding, ID/EX register with valid/ready.
// Define ID_PIPE_LOAD_INTERLOCK_EN to hold decode while a matching forwarding source is an unfinished load.
module id_pipe #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_FWD = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        if_valid_i,
  input  logic [ADDR_W-1:0]           if_pc_i,
  input  logic [31:0]                 if_inst_i,
  output logic                        if_ready_o,
  input  logic                        flush_i,
  output logic                        reg1_read_o,
  output logic                        reg2_read_o,
  output logic [REG_AW-1:0]           reg1_addr_o,
  output logic [REG_AW-1:0]           reg2_addr_o,
  input  logic [DATA_W-1:0]           reg1_data_i,
  input  logic [DATA_W-1:0]           reg2_data_i,
  input  logic [NUM_FWD-1:0]          fwd_wreg_i,
  input  logic [NUM_FWD*REG_AW-1:0]   fwd_waddr_i,
  input  logic [NUM_FWD*DATA_W-1:0]   fwd_wdata_i,
  input  logic [NUM_FWD-1:0]          fwd_load_i,
  input  logic                        ex_ready_i,
  output logic                        ex_valid_o,
  output logic [ADDR_W-1:0]           ex_pc_o,
  output logic [2:0]                  alusel_o,
  output logic [7:0]                  aluop_o,
  output logic [DATA_W-1:0]           reg1_data_o,
  output logic [DATA_W-1:0]           reg2_data_o,
  output logic [REG_AW-1:0]           waddr_o,
  output logic                        wreg_o,
  output logic                        inst_invalid_o,
  output logic                        stall_o
);

  localparam logic [2:0] SEL_NOP   = 3'd0;
  localparam logic [2:0] SEL_LOGIC = 3'd1;
  localparam logic [2:0] SEL_SHIFT = 3'd2;
  localparam logic [2:0] SEL_MOVE  = 3'd3;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_AND  = 8'h24;
  localparam logic [7:0] OP_OR   = 8'h25;
  localparam logic [7:0] OP_XOR  = 8'h26;
  localparam logic [7:0] OP_NOR  = 8'h27;
  localparam logic [7:0] OP_SLL  = 8'h7C;
  localparam logic [7:0] OP_SRL  = 8'h02;
  localparam logic [7:0] OP_SRA  = 8'h03;
  localparam logic [7:0] OP_MOVZ = 8'h0A;
  localparam logic [7:0] OP_MOVN = 8'h0B;
  localparam logic [7:0] OP_MFHI = 8'h10;
  localparam logic [7:0] OP_MTHI = 8'h11;
  localparam logic [7:0] OP_MFLO = 8'h12;
  localparam logic [7:0] OP_MTLO = 8'h13;

  localparam logic [5:0] OPC_SPECIAL = 6'b000000;
  localparam logic [5:0] OPC_ANDI    = 6'b001100;
  localparam logic [5:0] OPC_ORI     = 6'b001101;
  localparam logic [5:0] OPC_XORI    = 6'b001110;
  localparam logic [5:0] OPC_LUI     = 6'b001111;

  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_SLLV = 6'b000100;
  localparam logic [5:0] F_SRLV = 6'b000110;
  localparam logic [5:0] F_SRAV = 6'b000111;
  localparam logic [5:0] F_MOVZ = 6'b001010;
  localparam logic [5:0] F_MOVN = 6'b001011;
  localparam logic [5:0] F_SYNC = 6'b001111;
  localparam logic [5:0] F_MFHI = 6'b010000;
  localparam logic [5:0] F_MTHI = 6'b010001;
  localparam logic [5:0] F_MFLO = 6'b010010;
  localparam logic [5:0] F_MTLO = 6'b010011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;

  // Stage p0: IF/ID slot
  logic              slot_vld_p0;
  logic [ADDR_W-1:0] slot_pc_p0;
  logic [31:0]       slot_inst_p0;

  logic [5:0]  opc, funct;
  logic [4:0]  rs, rt, rd, sa;
  logic [15:0] imm16;

  assign opc   = slot_inst_p0[31:26];
  assign rs    = slot_inst_p0[25:21];
  assign rt    = slot_inst_p0[20:16];
  assign rd    = slot_inst_p0[15:11];
  assign sa    = slot_inst_p0[10:6];
  assign funct = slot_inst_p0[5:0];
  assign imm16 = slot_inst_p0[15:0];

  logic [2:0]        d_sel;
  logic [7:0]        d_op;
  logic              d_re1, d_re2, d_wreg, d_inv, d_movz, d_movn;
  logic [REG_AW-1:0] d_waddr;
  logic [DATA_W-1:0] d_imm;

  always_comb begin
    d_sel   = SEL_NOP;
    d_op    = OP_NOP;
    d_re1   = 1'b0;
    d_re2   = 1'b0;
    d_wreg  = 1'b0;
    d_waddr = '0;
    d_imm   = '0;
    d_inv   = 1'b1;
    d_movz  = 1'b0;
    d_movn  = 1'b0;
    case (opc)
      OPC_SPECIAL: begin
        case (funct)
          F_AND, F_OR, F_XOR, F_NOR: if (sa == 5'd0) begin
            d_inv = 1'b0; d_sel = SEL_LOGIC; d_re1 = 1'b1; d_re2 = 1'b1;
            d_wreg = 1'b1; d_waddr = REG_AW'(rd);
            case (funct)
              F_AND:   d_op = OP_AND;
              F_OR:    d_op = OP_OR;
              F_XOR:   d_op = OP_XOR;
              default: d_op = OP_NOR;
            endcase
          end
          F_SLL, F_SRL, F_SRA: if (rs == 5'd0) begin
            d_inv = 1'b0; d_sel = SEL_SHIFT; d_re2 = 1'b1; d_imm = DATA_W'(sa);
            d_wreg = 1'b1; d_waddr = REG_AW'(rd);
            d_op = (funct == F_SLL) ? OP_SLL : (funct == F_SRL) ? OP_SRL : OP_SRA;
          end
          F_SLLV, F_SRLV, F_SRAV: if (sa == 5'd0) begin
            d_inv = 1'b0; d_sel = SEL_SHIFT; d_re1 = 1'b1; d_re2 = 1'b1;
            d_wreg = 1'b1; d_waddr = REG_AW'(rd);
            d_op = (funct == F_SLLV) ? OP_SLL : (funct == F_SRLV) ? OP_SRL : OP_SRA;
          end
          F_MOVZ, F_MOVN: if (sa == 5'd0) begin
            d_inv = 1'b0; d_sel = SEL_MOVE; d_re1 = 1'b1; d_re2 = 1'b1;
            d_waddr = REG_AW'(rd);
            d_movz = (funct == F_MOVZ);
            d_movn = (funct == F_MOVN);
            d_op = (funct == F_MOVZ) ? OP_MOVZ : OP_MOVN;
          end
          F_MFHI, F_MFLO: if (rs == 5'd0 && rt == 5'd0 && sa == 5'd0) begin
            d_inv = 1'b0; d_sel = SEL_MOVE; d_wreg = 1'b1; d_waddr = REG_AW'(rd);
            d_op = (funct == F_MFHI) ? OP_MFHI : OP_MFLO;
          end
          F_MTHI, F_MTLO: if (rt == 5'd0 && rd == 5'd0 && sa == 5'd0) begin
            d_inv = 1'b0; d_re1 = 1'b1;
            d_op = (funct == F_MTHI) ? OP_MTHI : OP_MTLO;
          end
          F_SYNC: if (rs == 5'd0 && rt == 5'd0 && rd == 5'd0) d_inv = 1'b0;
          default: ;
        endcase
      end
      OPC_ANDI, OPC_ORI, OPC_XORI: begin
        d_inv = 1'b0; d_sel = SEL_LOGIC; d_re1 = 1'b1; d_imm = DATA_W'(imm16);
        d_wreg = 1'b1; d_waddr = REG_AW'(rt);
        d_op = (opc == OPC_ANDI) ? OP_AND : (opc == OPC_ORI) ? OP_OR : OP_XOR;
      end
      OPC_LUI: if (rs == 5'd0) begin
        d_inv = 1'b0; d_sel = SEL_LOGIC; d_op = OP_OR; d_re1 = 1'b1;
        d_imm = DATA_W'({imm16, 16'h0000});
        d_wreg = 1'b1; d_waddr = REG_AW'(rt);
      end
      default: ;
    endcase
  end

  assign reg1_read_o = slot_vld_p0 & d_re1;
  assign reg2_read_o = slot_vld_p0 & d_re2;
  assign reg1_addr_o = REG_AW'(rs);
  assign reg2_addr_o = REG_AW'(rt);

  // Walk sources oldest to youngest so the lowest matching index ends up winning.
  logic [DATA_W-1:0] opnd [2];
  logic [1:0]        port_ld;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      logic              re;
      logic [REG_AW-1:0] a;
      re         = (p == 0) ? reg1_read_o : reg2_read_o;
      a          = (p == 0) ? reg1_addr_o : reg2_addr_o;
      opnd[p]    = (p == 0) ? reg1_data_i : reg2_data_i;
      port_ld[p] = 1'b0;
      if (!re) begin
        opnd[p] = d_imm;
      end else if (a == '0) begin
        opnd[p] = '0;
      end else begin
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
          if (fwd_wreg_i[k] && fwd_waddr_i[k*REG_AW +: REG_AW] == a) begin
            opnd[p]    = fwd_wdata_i[k*DATA_W +: DATA_W];
            port_ld[p] = fwd_load_i[k];
          end
        end
      end
    end
  end

  logic hazard;
`ifdef ID_PIPE_LOAD_INTERLOCK_EN
  assign hazard = slot_vld_p0 & (|port_ld);
`else
  logic unused_load;
  assign unused_load = ^{fwd_load_i, port_ld};
  assign hazard = 1'b0;
`endif

  logic d_wreg_res;
  assign d_wreg_res = d_movz ? (opnd[1] == '0) :
                      d_movn ? (opnd[1] != '0) : d_wreg;

  logic vld_p1;
  logic advance;
  assign advance    = slot_vld_p0 & ~hazard & (~vld_p1 | ex_ready_i);
  assign if_ready_o = ~rst & (~slot_vld_p0 | advance);
  assign stall_o    = hazard;

  always_ff @(posedge clk) begin
    if (rst)                          slot_vld_p0 <= 1'b0;
    else if (flush_i)                 slot_vld_p0 <= 1'b0;
    else if (if_valid_i && if_ready_o) slot_vld_p0 <= 1'b1;
    else if (advance)                 slot_vld_p0 <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (if_valid_i && if_ready_o) begin
      slot_pc_p0   <= if_pc_i;
      slot_inst_p0 <= if_inst_i;
    end
  end

  // Stage p1: ID/EX register
  logic [ADDR_W-1:0] pc_p1;
  logic [2:0]        sel_p1;
  logic [7:0]        op_p1;
  logic [DATA_W-1:0] op1_p1, op2_p1;
  logic [REG_AW-1:0] waddr_p1;
  logic              wreg_p1, inv_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      pc_p1    <= '0;
      sel_p1   <= '0;
      op_p1    <= '0;
      op1_p1   <= '0;
      op2_p1   <= '0;
      waddr_p1 <= '0;
      wreg_p1  <= 1'b0;
      inv_p1   <= 1'b0;
    end else if (flush_i) begin
      vld_p1 <= 1'b0;
    end else if (advance) begin
      vld_p1   <= 1'b1;
      pc_p1    <= slot_pc_p0;
      sel_p1   <= d_sel;
      op_p1    <= d_op;
      op1_p1   <= opnd[0];
      op2_p1   <= opnd[1];
      waddr_p1 <= d_waddr;
      wreg_p1  <= d_wreg_res;
      inv_p1   <= d_inv;
    end else if (ex_ready_i) begin
      vld_p1 <= 1'b0;
    end
  end

  assign ex_valid_o     = vld_p1;
  assign ex_pc_o        = pc_p1;
  assign alusel_o       = sel_p1;
  assign aluop_o        = op_p1;
  assign reg1_data_o    = op1_p1;
  assign reg2_data_o    = op2_p1;
  assign waddr_o        = waddr_p1;
  assign wreg_o         = wreg_p1;
  assign inst_invalid_o = inv_p1;

endmodule

// File: tb/tb_id_pipe.sv
// Scoreboard bench for id_pipe: directed instructions with hand-computed ID/EX results.
module tb_id_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid_i, if_ready_o, flush_i;
  logic [31:0] if_pc_i, if_inst_i;
  logic        reg1_read_o, reg2_read_o;
  logic [4:0]  reg1_addr_o, reg2_addr_o;
  logic [31:0] reg1_data_i, reg2_data_i;
  logic [1:0]  fwd_wreg_i, fwd_load_i;
  logic [9:0]  fwd_waddr_i;
  logic [63:0] fwd_wdata_i;
  logic        ex_ready_i, ex_valid_o;
  logic [31:0] ex_pc_o, reg1_data_o, reg2_data_o;
  logic [2:0]  alusel_o;
  logic [7:0]  aluop_o;
  logic [4:0]  waddr_o;
  logic        wreg_o, inst_invalid_o, stall_o;

  id_pipe dut (
    .clk(clk), .rst(rst), .if_valid_i(if_valid_i), .if_pc_i(if_pc_i), .if_inst_i(if_inst_i),
    .if_ready_o(if_ready_o), .flush_i(flush_i), .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
    .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o), .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .fwd_wreg_i(fwd_wreg_i), .fwd_waddr_i(fwd_waddr_i), .fwd_wdata_i(fwd_wdata_i), .fwd_load_i(fwd_load_i),
    .ex_ready_i(ex_ready_i), .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o), .alusel_o(alusel_o),
    .aluop_o(aluop_o), .reg1_data_o(reg1_data_o), .reg2_data_o(reg2_data_o), .waddr_o(waddr_o),
    .wreg_o(wreg_o), .inst_invalid_o(inst_invalid_o), .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  // Register file stand-in: rN reads as 0x1100 | N (r0 deliberately nonzero).
  assign reg1_data_i = 32'h0000_1100 | {27'b0, reg1_addr_o};
  assign reg2_data_i = 32'h0000_1100 | {27'b0, reg2_addr_o};

  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  sel;
    logic [7:0]  op;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [4:0]  wa;
    logic        we;
    logic        inv;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   dummy;

  function automatic exp_t mk(input logic [31:0] pc, input logic [2:0] sel, input logic [7:0] op,
                              input logic [31:0] r1, input logic [31:0] r2, input logic [4:0] wa,
                              input logic we, input logic inv);
    mk = '{pc: pc, sel: sel, op: op, r1: r1, r2: r2, wa: wa, we: we, inv: inv};
  endfunction

  always @(negedge clk) begin
    exp_t e, a;
    if (!rst && ex_valid_o && ex_ready_i) begin
      a = {ex_pc_o, alusel_o, aluop_o, reg1_data_o, reg2_data_o, waddr_o, wreg_o, inst_invalid_o};
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL ex_unexpected: got pc=%h with no instruction outstanding", ex_pc_o);
      end else begin
        e = sb.pop_front();
        if (a !== e) begin
          n_bad++;
          $display("FAIL ex_out: got pc=%h sel=%0d op=%h r1=%h r2=%h wa=%0d we=%b inv=%b, expected pc=%h sel=%0d op=%h r1=%h r2=%h wa=%0d we=%b inv=%b",
                   a.pc, a.sel, a.op, a.r1, a.r2, a.wa, a.we, a.inv, e.pc, e.sel, e.op, e.r1, e.r2, e.wa, e.we, e.inv);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_fwd(input int k, input logic we, input logic [4:0] a, input logic [31:0] d, input logic ld);
    fwd_wreg_i[k]           = we;
    fwd_waddr_i[k*5 +: 5]   = a;
    fwd_wdata_i[k*32 +: 32] = d;
    fwd_load_i[k]           = ld;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] inst, input logic [31:0] pc, input logic push,
                      input exp_t e, output int waited);
    logic ok;
    ok = 1'b0;
    waited = 0;
    if_inst_i = inst;
    if_pc_i = pc;
    if_valid_i = 1'b1;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (if_ready_o) ok = 1'b1;
      else waited++;
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: pc=%h never accepted", pc);
    end else if (push) begin
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if_valid_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    rst = 1'b1; if_valid_i = 1'b0; if_pc_i = '0; if_inst_i = '0; flush_i = 1'b0; ex_ready_i = 1'b1;
    fwd_wreg_i = '0; fwd_waddr_i = '0; fwd_wdata_i = '0; fwd_load_i = '0;
    @(negedge clk);
    chk("ready_in_reset", {31'b0, if_ready_o}, 32'd0);
    cyc(2);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ex_valid", {31'b0, ex_valid_o}, 32'd0);
    chk("rst_ex_pc", ex_pc_o, 32'd0);
    chk("rst_aluop", {24'b0, aluop_o}, 32'd0);
    chk("rst_reg1", reg1_data_o, 32'd0);
    chk("rst_wreg_inv_stall", {29'b0, wreg_o, inst_invalid_o, stall_o}, 32'd0);
    chk("rst_if_ready", {31'b0, if_ready_o}, 32'd1);
    cyc(1);

    // Back-to-back ORI then OR with r1 forwarded from source 0
    set_fwd(0, 1'b1, 5'd1, 32'h1234, 1'b0);
    send(32'h3401_1234, 32'h100, 1'b1, mk(32'h100, 3'd1, 8'h25, 32'h0, 32'h1234, 5'd1, 1'b1, 1'b0), dummy);
    send(32'h0021_1025, 32'h104, 1'b1, mk(32'h104, 3'd1, 8'h25, 32'h1234, 32'h1234, 5'd2, 1'b1, 1'b0), w);
    chk("throughput_wait", w, 32'd0);
    cyc(3);

    // Both sources write r3: source 0 wins; then source 1 alone
    set_fwd(0, 1'b1, 5'd3, 32'hAAAA, 1'b0);
    set_fwd(1, 1'b1, 5'd3, 32'hBBBB, 1'b0);
    send(32'h0060_2825, 32'h200, 1'b1, mk(32'h200, 3'd1, 8'h25, 32'hAAAA, 32'h0, 5'd5, 1'b1, 1'b0), dummy);
    cyc(2);
    set_fwd(0, 1'b0, 5'd3, 32'hAAAA, 1'b0);
    send(32'h0067_3026, 32'h204, 1'b1, mk(32'h204, 3'd1, 8'h26, 32'hBBBB, 32'h1107, 5'd6, 1'b1, 1'b0), dummy);
    cyc(2);
    set_fwd(1, 1'b0, 5'd0, 32'h0, 1'b0);

    // MOVZ/MOVN write enable from the resolved rt value
    set_fwd(0, 1'b1, 5'd18, 32'h0, 1'b0);
    send(32'h0232_800A, 32'h300, 1'b1, mk(32'h300, 3'd3, 8'h0A, 32'h1111, 32'h0, 5'd16, 1'b1, 1'b0), dummy);
    send(32'h0232_800B, 32'h304, 1'b1, mk(32'h304, 3'd3, 8'h0B, 32'h1111, 32'h0, 5'd16, 1'b0, 1'b0), dummy);
    cyc(2);
    set_fwd(0, 1'b0, 5'd0, 32'h0, 1'b0);
    send(32'h0232_800B, 32'h308, 1'b1, mk(32'h308, 3'd3, 8'h0B, 32'h1111, 32'h1112, 5'd16, 1'b1, 1'b0), dummy);
    // LUI, valid SLL, SLL with nonzero rs
    send(32'h3C13_BEEF, 32'h310, 1'b1, mk(32'h310, 3'd1, 8'h25, 32'h0, 32'hBEEF0000, 5'd19, 1'b1, 1'b0), dummy);
    send(32'h000E_68C0, 32'h320, 1'b1, mk(32'h320, 3'd2, 8'h7C, 32'h3, 32'h110E, 5'd13, 1'b1, 1'b0), dummy);
    send(32'h002E_68C0, 32'h324, 1'b1, mk(32'h324, 3'd0, 8'h00, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1), dummy);
    cyc(2);
    // r0 is never forwarded
    set_fwd(0, 1'b1, 5'd0, 32'hFFFF, 1'b0);
    send(32'h0000_7825, 32'h330, 1'b1, mk(32'h330, 3'd1, 8'h25, 32'h0, 32'h0, 5'd15, 1'b1, 1'b0), dummy);
    cyc(2);

    // Load on source 0 for r4 held two cycles
    set_fwd(0, 1'b1, 5'd4, 32'h4444, 1'b1);
    send(32'h0080_4024, 32'h400, 1'b1, mk(32'h400, 3'd1, 8'h24, 32'h4444, 32'h0, 5'd8, 1'b1, 1'b0), dummy);
    @(negedge clk);
`ifdef ID_PIPE_LOAD_INTERLOCK_EN
    chk("ld_stall_c1", {29'b0, stall_o, if_ready_o, ex_valid_o}, 32'b100);
`else
    chk("ld_nostall_c1", {29'b0, stall_o, if_ready_o, ex_valid_o}, 32'b010);
`endif
    cyc(1);
    @(negedge clk);
`ifdef ID_PIPE_LOAD_INTERLOCK_EN
    chk("ld_stall_c2", {29'b0, stall_o, if_ready_o, ex_valid_o}, 32'b100);
`else
    chk("ld_nostall_c2", {29'b0, stall_o, ex_valid_o}, 32'b01);
`endif
    cyc(1);
    set_fwd(0, 1'b1, 5'd4, 32'h4444, 1'b0);
    @(negedge clk);
    chk("ld_release_stall", {31'b0, stall_o}, 32'd0);
    cyc(3);

    // Source 0 (not a load) shadows a load on source 1
    set_fwd(0, 1'b1, 5'd9, 32'h9999, 1'b0);
    set_fwd(1, 1'b1, 5'd9, 32'h7777, 1'b1);
    send(32'h0120_5025, 32'h410, 1'b1, mk(32'h410, 3'd1, 8'h25, 32'h9999, 32'h0, 5'd10, 1'b1, 1'b0), dummy);
    @(negedge clk);
    chk("prio_no_stall", {31'b0, stall_o}, 32'd0);
    cyc(3);
    set_fwd(0, 1'b0, 5'd0, 32'h0, 1'b0);
    set_fwd(1, 1'b0, 5'd0, 32'h0, 1'b0);

    // Back-pressure with two instructions queued
    ex_ready_i = 1'b0;
    send(32'h340B_00FF, 32'h500, 1'b1, mk(32'h500, 3'd1, 8'h25, 32'h0, 32'hFF, 5'd11, 1'b1, 1'b0), dummy);
    send(32'h384C_8001, 32'h504, 1'b1, mk(32'h504, 3'd1, 8'h26, 32'h1102, 32'h8001, 5'd12, 1'b1, 1'b0), dummy);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold_pc", ex_pc_o, 32'h500);
      chk("bp_hold_flags", {29'b0, ex_valid_o, if_ready_o, 1'b0} | {24'b0, reg2_data_o[7:0]} << 8, 32'h0000_FF04);
      cyc(1);
    end
    ex_ready_i = 1'b1;
    cyc(3);
    @(negedge clk);
    chk("bp_drained", sb.size(), 32'd0);
    cyc(1);

    // Flush with ID/EX and slot both full, fetch offering
    ex_ready_i = 1'b0;
    send(32'h3401_0001, 32'h600, 1'b0, '0, dummy);
    send(32'h3402_0002, 32'h604, 1'b0, '0, dummy);
    if_inst_i = 32'h3403_0003; if_pc_i = 32'h608; if_valid_i = 1'b1; flush_i = 1'b1;
    cyc(1);
    flush_i = 1'b0; if_valid_i = 1'b0;
    @(negedge clk);
    chk("flushA_ex_valid", {31'b0, ex_valid_o}, 32'd0);
    chk("flushA_slot_empty", {31'b0, if_ready_o}, 32'd1);
    ex_ready_i = 1'b1;
    cyc(1);
    @(negedge clk);
    chk("flushA_after", {31'b0, ex_valid_o}, 32'd0);
    cyc(1);

    // Flush beats a simultaneous advance and fetch accept
    send(32'h3404_0004, 32'h610, 1'b0, '0, dummy);
    if_inst_i = 32'h3405_0005; if_pc_i = 32'h614; if_valid_i = 1'b1; flush_i = 1'b1;
    @(negedge clk);
    chk("flushB_would_accept", {31'b0, if_ready_o}, 32'd1);
    cyc(1);
    flush_i = 1'b0; if_valid_i = 1'b0;
    @(negedge clk);
    chk("flushB_ex_valid", {31'b0, ex_valid_o}, 32'd0);
    cyc(1);
    @(negedge clk);
    chk("flushB_dropped", {31'b0, ex_valid_o}, 32'd0);
    cyc(1);

    // Reset while back-pressured drops both instructions
    ex_ready_i = 1'b0;
    send(32'h3406_0006, 32'h700, 1'b0, '0, dummy);
    send(32'h3407_0007, 32'h704, 1'b0, '0, dummy);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready", {31'b0, if_ready_o}, 32'd0);
    cyc(1);
    rst = 1'b0;
    ex_ready_i = 1'b1;
    @(negedge clk);
    chk("rst_mid_ex", {31'b0, ex_valid_o}, 32'd0);
    chk("rst_mid_pc", ex_pc_o, 32'd0);
    cyc(1);
    @(negedge clk);
    chk("rst_mid_slot", {31'b0, ex_valid_o}, 32'd0);

    cyc(3);
    @(negedge clk);
    chk("final_queue_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/id_pipe.md
# id_pipe

Parametrised, pipelined successor to the combinational decode stage: owns the IF/ID slot register and the ID/EX output register, decodes the current MIPS32 subset, resolves operands through NUM_FWD prioritised forwarding sources, and applies valid/ready back-pressure. It sits between the fetch unit and the execute stage. A load-use interlock holds decode until the load data can be forwarded.

## Interface
- DATA_W, 32, register/data width
- ADDR_W, 32, PC width
- REG_AW, 5, register-file address width
- NUM_FWD, 2, forwarding sources; index 0 = youngest (ex), highest priority
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; synchronous and active-high
- if_valid_i  in  1  fetch offers an instruction
- if_pc_i  in  ADDR_W  PC of offered instruction
- if_inst_i  in  32  offered instruction word
- if_ready_o  out  1  slot will accept this cycle
- flush_i  in  1  discard all held instructions
- reg1_read_o / reg2_read_o  out  1  regfile read enables (combinational from slot)
- reg1_addr_o / reg2_addr_o  out  REG_AW  regfile read addresses (rs / rt)
- reg1_data_i / reg2_data_i  in  DATA_W  regfile read data, same cycle
- fwd_wreg_i  in  NUM_FWD  source k writes a register
- fwd_waddr_i  in  NUM_FWD*REG_AW  source k destination, packed, k at [k*REG_AW +: REG_AW]
- fwd_wdata_i  in  NUM_FWD*DATA_W  source k result, packed likewise
- fwd_load_i  in  NUM_FWD  source k is a load whose data is not yet valid
- ex_ready_i  in  1  execute accepts ex_valid_o
- ex_valid_o  out  1  ID/EX register holds an instruction
- ex_pc_o  out  ADDR_W  its PC
- alusel_o, aluop_o  out  AluSelBus / AluOpBus widths  operation class / subop
- reg1_data_o, reg2_data_o  out  DATA_W  resolved operands
- waddr_o  out  REG_AW  destination
- wreg_o  out  1  destination write enable
- inst_invalid_o  out  1  opcode/function not in decode set, or reserved fields nonzero
- stall_o  out  1  slot held by interlock (performance counter tap)

## Operation
- Decode set: AND/OR/XOR/NOR, ANDI/ORI/XORI (zero-extended imm), LUI (rs must be 0, imm<<16), SLL/SRL/SRA (rs=0, sa as imm), SLLV/SRLV/SRAV, MOVZ/MOVN, MFHI/MFLO/MTHI/MTLO, SYNC (NOP). Reserved-field rules unchanged; violation → NOP encoding, wreg_o=0, inst_invalid_o=1.
- Operand resolution per port p with read enable: if addr==0 → 0 (never forwarded); else lowest k with fwd_wreg_i[k] and fwd_waddr_i[k]==addr supplies fwd_wdata_i[k]; else regfile data. Read disabled → imm.
- MOVZ/MOVN wreg_o computed from resolved rt value.
- Interlock: hazard = slot valid ∧ ∃ enabled port, its matching source k (per priority above) has fwd_load_i[k]=1, addr≠0.
- advance = slot_valid ∧ ¬hazard ∧ (¬ex_valid_o ∨ ex_ready_i).
- if_ready_o = ¬rst ∧ (¬slot_valid ∨ advance).
- On advance: ID/EX register loads decode result, ex_valid_o=1. If ex_ready_i=1 and no advance: ex_valid_o←0. Otherwise ID/EX holds all fields stable.
- Slot loads on if_valid_i ∧ if_ready_o; clears on advance without new load.

## Timing
- Reset (rst=1 at edge): slot_valid=0, ex_valid_o=0, ex_pc_o/alusel_o/aluop_o/reg*_data_o/waddr_o=0, wreg_o=0, inst_invalid_o=0, stall_o=0; if_ready_o=0 while rst high. Reset mid-stall drops both instructions.
- Latency: accepted at edge N → ex_valid_o at edge N+1 (earliest); throughput 1/cycle.
- stall_o = slot_valid ∧ hazard (combinational).
- flush_i at edge: slot_valid←0, ex_valid_o←0, overriding advance and any simultaneous fetch accept.
- Back-pressure: ex_valid_o ∧ ¬ex_ready_i freezes ID/EX; slot holds; operands re-resolved each cycle until advance.
- Simultaneous hits on sources 0 and 1 to the same register: source 0 wins, including for interlock decision.

## Configuration
- ID_PIPE_LOAD_INTERLOCK_EN defined: interlock as above.
- Undefined: fwd_load_i ignored, hazard≡0, stall_o tied 0; forwarded data taken as valid.

## Test plan
- ORI r1,r0,0x1234 then OR r2,r1,r1 back-to-back, source 0 returns 0x1234 → second instr's reg1/reg2 = 0x00001234, one issue per cycle.
- Source 0 and 1 both write r3 (0xAAAA / 0xBBBB), ADD-class read of r3 → operand 0xAAAA.
- fwd_load_i[0]=1 on r4 for 2 cycles, slot reads r4 → stall_o=1, if_ready_o=0, ex_valid_o=0 two cycles; third cycle issues with forwarded data.
- ex_ready_i=0 for 3 cycles with two instructions queued → ex outputs constant, if_ready_o=0, no loss or duplication after release.
- flush_i with both slots valid and if_valid_i=1 → next cycle ex_valid_o=0, slot empty, offered instruction dropped.
- SLL with rs=5'b00001 → inst_invalid_o=1, wreg_o=0; read of r0 with source writing r0=0xFFFF → operand 0.
